// File: rtl/cmp_stream_pkg.sv
// Shared types and defaults for the cmp_stream comparator slice.
package cmp_stream_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    OUT_GT = 2'd0,
    OUT_EQ = 2'd1,
    OUT_LT = 2'd2
  } outcome_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/cmp_stream_if.sv
// Operand/result handshake bundle between a producer/consumer and cmp_stream.
interface cmp_stream_if #(
  parameter int W = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         out_gt;
  logic         out_eq;
  logic         out_lt;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gt, out_eq, out_lt
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gt, out_eq, out_lt
  );

endinterface

// File: rtl/cmp_stream_cmp3_core.sv
// Pure combinational unsigned three-way compare of two W-bit operands.
module cmp3_core
  import cmp_stream_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output outcome_t     res_o
);

  always_comb begin
    res_o = OUT_EQ;
    if (a_i > b_i)      res_o = OUT_GT;
    else if (a_i < b_i) res_o = OUT_LT;
  end

endmodule

// File: rtl/cmp_stream.sv
// Registered compare stream: 2-entry result FIFO plus saturating outcome counters.
module cmp_stream
  import cmp_stream_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_stream_if.slave   bus,
  input  logic          clr,
  output logic [CW-1:0] cnt_gt,
  output logic [CW-1:0] cnt_eq,
  output logic [CW-1:0] cnt_lt
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t   state_q, state_d;
  outcome_t slot0_q, slot0_d;
  outcome_t slot1_q, slot1_d;
  outcome_t res;
  logic     accept, deliver;
  logic [CW-1:0] cnt_gt_q, cnt_eq_q, cnt_lt_q;

  cmp3_core #(.W(W)) u_core (
    .a_i   (bus.in_a),
    .b_i   (bus.in_b),
    .res_o (res)
  );

  // in_ready depends on registered state only, so out_ready never reaches it.
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_gt    = bus.out_valid && (slot0_q == OUT_GT);
  assign bus.out_eq    = bus.out_valid && (slot0_q == OUT_EQ);
  assign bus.out_lt    = bus.out_valid && (slot0_q == OUT_LT);

  assign accept  = bus.in_valid  && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          slot0_d = res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          slot0_d = res;
        end else if (accept) begin
          slot1_d = res;
          state_d = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          slot0_d = slot1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      slot0_q <= OUT_EQ;
      slot1_q <= OUT_EQ;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else if (clr) begin
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else if (accept) begin
      case (res)
        OUT_GT:  if (cnt_gt_q != '1) cnt_gt_q <= cnt_gt_q + CNT_ONE;
        OUT_EQ:  if (cnt_eq_q != '1) cnt_eq_q <= cnt_eq_q + CNT_ONE;
        OUT_LT:  if (cnt_lt_q != '1) cnt_lt_q <= cnt_lt_q + CNT_ONE;
        default: ;
      endcase
    end
  end

  assign cnt_gt = cnt_gt_q;
  assign cnt_eq = cnt_eq_q;
  assign cnt_lt = cnt_lt_q;

endmodule

// File: doc/cmp_stream.md
CMP_STREAM -- requirements
Module: cmp_stream

Interface
REQ-001 Parameter W, default 16: operand width in bits; bit W-1 is the MSB.
REQ-002 Parameter CW, default 8: width of each result counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair on in_a/in_b is offered.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 in_a  input  W  operand A, unsigned.
REQ-008 in_b  input  W  operand B, unsigned.
REQ-009 out_valid  output  1  head result is presented.
REQ-010 out_ready  input  1  consumer takes the head result this cycle.
REQ-011 out_gt  output  1  head result: A > B.
REQ-012 out_eq  output  1  head result: A == B.
REQ-013 out_lt  output  1  head result: A < B.
REQ-014 clr  input  1  synchronous clear of all three counters.
REQ-015 cnt_gt, cnt_eq, cnt_lt  output  CW each  count of accepted pairs per outcome.

Function
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; deliver occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Compare is unsigned over all W bits, MSB first; exactly one of gt/eq/lt is 1 per result.
REQ-018 The comparison is registered at accept; result is visible on the out_* ports one cycle later at the earliest.
REQ-019 Results are held in a 2-entry FIFO; delivery order equals accept order.
REQ-020 Occupancy FSM states: EMPTY, ONE, FULL.
REQ-021 Transitions: EMPTY -accept-> ONE; ONE -accept only-> FULL; ONE -deliver only-> EMPTY; ONE -accept and deliver-> ONE; FULL -deliver-> ONE.
REQ-022 in_ready is 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-023 out_valid is 1 in ONE and FULL, 0 in EMPTY.
REQ-024 out_gt/out_eq/out_lt are all 0 when out_valid=0.
REQ-025 out_* hold stable while out_valid=1 and out_ready=0.
REQ-026 On each accept, the counter for the computed outcome increments by 1.
REQ-027 Counters saturate at 2^CW-1; there is no wrap-around.
REQ-028 clr sets all counters to 0 on the next edge and takes priority over a same-cycle increment; the FIFO is not affected.
REQ-029 in_a/in_b are ignored when in_valid=0 or in_ready=0.

Reset
REQ-030 rst_n=0 immediately forces state EMPTY, in_ready=1, out_valid=0, out_gt=out_eq=out_lt=0, and all counters to 0, independent of clk.
REQ-031 An in-flight result held at reset is discarded; accept resumes on the first edge after rst_n rises.

Structure
REQ-032 A shared package holds the outcome encoding type (GT, EQ, LT), the occupancy state type, and the default W/CW constants.
REQ-033 The pure combinational W-bit three-way compare is a separate sub-module, cmp3_core, instantiated once.

Verification
REQ-034 Reset, then accept A=0x8000, B=0x7FFF -> next cycle out_gt=1, out_eq=0, out_lt=0, and cnt_gt=1.
REQ-035 With out_ready=0, accept three pairs back-to-back (0x1234/0x1234, 0x0001/0x0002, 0xFFFF/0x0000) -> in_ready=0 after the second accept, the third is held off; then raise out_ready -> deliveries in order eq, lt, gt.
REQ-036 In ONE state with accept and deliver in the same cycle -> state stays ONE, and out_valid never drops.
REQ-037 Accept 300 equal pairs (CW=8) -> cnt_eq=255; then clr with a simultaneous accept -> all counters 0.
REQ-038 Assert rst_n=0 mid-cycle while FULL -> out_valid=0 and counters 0 before the next clk edge.
